// File: rtl/gl_filter_pkg.sv
//==============================================================================
// Module      : gl_filter_pkg
// Description : Widths, kernel coefficients and saturation bounds shared by
//               the Gaussian / Laplacian 3x3 convolution channels.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package gl_filter_pkg;

    localparam int PIX_W       = 8;
    localparam int LAP_W       = 9;
    localparam int LATENCY     = 3;

    localparam int GAUSS_SUM_W = 12;
    localparam int GAUSS_SHIFT = 4;
    localparam int LAP_SUM_W   = 11;

    typedef enum logic {
        GAUSS   = 1'b0,
        LAPLACE = 1'b1
    } kernel_e;

    typedef logic [PIX_W-1:0] pix_t;
    // Row-major window, element 0 = top-left, 4 = centre, 8 = bottom-right
    typedef pix_t [8:0] win_t;

    localparam logic [GAUSS_SUM_W-1:0] G_K_CORNER = 12'd1;
    localparam logic [GAUSS_SUM_W-1:0] G_K_EDGE   = 12'd2;
    localparam logic [GAUSS_SUM_W-1:0] G_K_CENTRE = 12'd4;

    localparam logic signed [LAP_SUM_W-1:0] L_K_CORNER = 11'sd0;
    localparam logic signed [LAP_SUM_W-1:0] L_K_EDGE   = -11'sd1;
    localparam logic signed [LAP_SUM_W-1:0] L_K_CENTRE = 11'sd4;

    localparam logic signed [LAP_W-1:0] LAP_MIN = -9'sd256;
    localparam logic signed [LAP_W-1:0] LAP_MAX = 9'sd255;

    function automatic logic [GAUSS_SUM_W-1:0] g_ext(input pix_t p);
        return GAUSS_SUM_W'(p);
    endfunction

    function automatic logic signed [LAP_SUM_W-1:0] l_ext(input pix_t p);
        return $signed(LAP_SUM_W'(p));
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv3x3_chan.sv
//==============================================================================
// Module      : conv3x3_chan
// Description : One enable-gated 3-stage 3x3 convolution channel with its
//               enable-run counter and done flag.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module conv3x3_chan
    import gl_filter_pkg::*;
#(
    parameter kernel_e KERNEL = GAUSS,
    parameter int      OUT_W  = (KERNEL == GAUSS) ? PIX_W : LAP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  win_t             i_win,
    output logic [OUT_W-1:0] o_data,
    output logic             o_done
);

    localparam logic [1:0] c_latency = 2'(LATENCY);

    win_t             r_win;
    logic [OUT_W-1:0] r_out;
    logic [1:0]       r_run;
    logic [1:0]       w_run_next;
    logic             r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win <= '0;
        end else if (i_en) begin
            r_win <= i_win;
        end
    end

    generate
        if (KERNEL == GAUSS) begin : g_gauss
            logic [GAUSS_SUM_W-1:0] w_sum;
            logic [GAUSS_SUM_W-1:0] r_sum;

            always_comb begin
                w_sum = G_K_CORNER * (g_ext(r_win[0]) + g_ext(r_win[2]) + g_ext(r_win[6]) + g_ext(r_win[8]))
                      + G_K_EDGE   * (g_ext(r_win[1]) + g_ext(r_win[3]) + g_ext(r_win[5]) + g_ext(r_win[7]))
                      + G_K_CENTRE * g_ext(r_win[4]);
            end

            // Max sum 4080 >> 4 = 255, so the narrowing never loses significant bits
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sum <= '0;
                    r_out <= '0;
                end else if (i_en) begin
                    r_sum <= w_sum;
                    r_out <= OUT_W'(r_sum >> GAUSS_SHIFT);
                end
            end
        end else begin : g_lap
            localparam logic signed [LAP_SUM_W-1:0] c_sum_max = LAP_SUM_W'(LAP_MAX);
            localparam logic signed [LAP_SUM_W-1:0] c_sum_min = LAP_SUM_W'(LAP_MIN);

            logic signed [LAP_SUM_W-1:0] w_sum;
            logic signed [LAP_SUM_W-1:0] r_sum;
            logic signed [LAP_W-1:0]     w_sat;
            logic                        w_unused_corners;

            // Corner taps carry a zero coefficient and are not summed
            assign w_unused_corners = ^{r_win[0], r_win[2], r_win[6], r_win[8]};

            always_comb begin
                w_sum = L_K_CENTRE * l_ext(r_win[4])
                      + L_K_EDGE   * (l_ext(r_win[1]) + l_ext(r_win[3]) + l_ext(r_win[5]) + l_ext(r_win[7]));
            end

            always_comb begin
                w_sat = LAP_W'(r_sum);
                if (r_sum > c_sum_max) begin
                    w_sat = LAP_MAX;
                end else if (r_sum < c_sum_min) begin
                    w_sat = LAP_MIN;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sum <= '0;
                    r_out <= '0;
                end else if (i_en) begin
                    r_sum <= w_sum;
                    r_out <= OUT_W'(w_sat);
                end
            end
        end
    endgenerate

    // Run counter saturates at LATENCY; done is registered from its next value
    always_comb begin
        w_run_next = 2'd0;
        if (i_en) begin
            w_run_next = (r_run == c_latency) ? c_latency : r_run + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run  <= 2'd0;
            r_done <= 1'b0;
        end else begin
            r_run  <= w_run_next;
            r_done <= (w_run_next == c_latency);
        end
    end

    assign o_data = r_out;
    assign o_done = r_done;

endmodule

`default_nettype wire

// File: rtl/gauss_laplacian_filter.sv
//==============================================================================
// Module      : gauss_laplacian_filter
// Description : Independent Gaussian (8-bit) and saturated Laplacian (9-bit
//               signed) 3x3 convolution channels.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module gauss_laplacian_filter
    import gl_filter_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             g_en_i,
    input  logic [PIX_W-1:0] g_data_i_0,
    input  logic [PIX_W-1:0] g_data_i_1,
    input  logic [PIX_W-1:0] g_data_i_2,
    input  logic [PIX_W-1:0] g_data_i_3,
    input  logic [PIX_W-1:0] g_data_i_4,
    input  logic [PIX_W-1:0] g_data_i_5,
    input  logic [PIX_W-1:0] g_data_i_6,
    input  logic [PIX_W-1:0] g_data_i_7,
    input  logic [PIX_W-1:0] g_data_i_8,
    output logic [PIX_W-1:0] g_data_o,
    output logic             g_done_o,
    input  logic             l_en_i,
    input  logic [PIX_W-1:0] l_data_i_0,
    input  logic [PIX_W-1:0] l_data_i_1,
    input  logic [PIX_W-1:0] l_data_i_2,
    input  logic [PIX_W-1:0] l_data_i_3,
    input  logic [PIX_W-1:0] l_data_i_4,
    input  logic [PIX_W-1:0] l_data_i_5,
    input  logic [PIX_W-1:0] l_data_i_6,
    input  logic [PIX_W-1:0] l_data_i_7,
    input  logic [PIX_W-1:0] l_data_i_8,
    output logic [LAP_W-1:0] l_data_o,
    output logic             l_done_o
);

    conv3x3_chan #(
        .KERNEL (GAUSS)
    ) u_gauss (
        .clk    (clk_i),
        .rst_n  (rst_i),
        .i_en   (g_en_i),
        .i_win  ({g_data_i_8, g_data_i_7, g_data_i_6, g_data_i_5, g_data_i_4,
                  g_data_i_3, g_data_i_2, g_data_i_1, g_data_i_0}),
        .o_data (g_data_o),
        .o_done (g_done_o)
    );

    conv3x3_chan #(
        .KERNEL (LAPLACE)
    ) u_laplace (
        .clk    (clk_i),
        .rst_n  (rst_i),
        .i_en   (l_en_i),
        .i_win  ({l_data_i_8, l_data_i_7, l_data_i_6, l_data_i_5, l_data_i_4,
                  l_data_i_3, l_data_i_2, l_data_i_1, l_data_i_0}),
        .o_data (l_data_o),
        .o_done (l_done_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_gauss_laplacian_filter.sv
//==============================================================================
// Module      : tb_gauss_laplacian_filter
// Description : Randomised self-checking bench for gauss_laplacian_filter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_gauss_laplacian_filter;

    typedef logic [7:0] pix8_t;
    typedef pix8_t [8:0] win8_t;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       g_en_i;
    logic       l_en_i;
    logic [7:0] g_win [9];
    logic [7:0] l_win [9];
    logic [7:0] g_data_o;
    logic       g_done_o;
    logic [8:0] l_data_o;
    logic       l_done_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: windows captured on enabled edges since reset, and run lengths
    win8_t g_hist[$];
    win8_t l_hist[$];
    int    g_run;
    int    l_run;

    always #5 clk_i = ~clk_i;

    gauss_laplacian_filter dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .g_en_i     (g_en_i),
        .g_data_i_0 (g_win[0]), .g_data_i_1 (g_win[1]), .g_data_i_2 (g_win[2]),
        .g_data_i_3 (g_win[3]), .g_data_i_4 (g_win[4]), .g_data_i_5 (g_win[5]),
        .g_data_i_6 (g_win[6]), .g_data_i_7 (g_win[7]), .g_data_i_8 (g_win[8]),
        .g_data_o   (g_data_o),
        .g_done_o   (g_done_o),
        .l_en_i     (l_en_i),
        .l_data_i_0 (l_win[0]), .l_data_i_1 (l_win[1]), .l_data_i_2 (l_win[2]),
        .l_data_i_3 (l_win[3]), .l_data_i_4 (l_win[4]), .l_data_i_5 (l_win[5]),
        .l_data_i_6 (l_win[6]), .l_data_i_7 (l_win[7]), .l_data_i_8 (l_win[8]),
        .l_data_o   (l_data_o),
        .l_done_o   (l_done_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic win8_t pack(input logic [7:0] w [9]);
        win8_t p;
        for (int i = 0; i < 9; i++) p[i] = w[i];
        return p;
    endfunction

    function automatic logic [7:0] gauss_ref(input win8_t w);
        int s;
        s = w[0] + w[2] + w[6] + w[8] + 2 * (w[1] + w[3] + w[5] + w[7]) + 4 * w[4];
        return 8'(s / 16);
    endfunction

    function automatic logic [8:0] lap_ref(input win8_t w);
        int s;
        s = 4 * int'(w[4]) - int'(w[1]) - int'(w[3]) - int'(w[5]) - int'(w[7]);
        if (s > 255)  s = 255;
        if (s < -256) s = -256;
        return 9'(s);
    endfunction

    task automatic model_clear();
        g_hist.delete();
        l_hist.delete();
        g_run = 0;
        l_run = 0;
    endtask

    task automatic compare_all(input string tag);
        logic [7:0] exp_g;
        logic [8:0] exp_l;
        exp_g = (g_hist.size() == 3) ? gauss_ref(g_hist[0]) : 8'd0;
        exp_l = (l_hist.size() == 3) ? lap_ref(l_hist[0]) : 9'd0;
        check({tag, "_g_data"}, 32'(g_data_o), 32'(exp_g));
        check({tag, "_g_done"}, 32'(g_done_o), 32'(g_run >= 3));
        check({tag, "_l_data"}, 32'(l_data_o), 32'(exp_l));
        check({tag, "_l_done"}, 32'(l_done_o), 32'(l_run >= 3));
    endtask

    // One clock: update the reference from the inputs seen at the edge, then compare
    task automatic step(input string tag);
        @(posedge clk_i);
        if (!rst_i) begin
            model_clear();
        end else begin
            if (g_en_i) begin
                g_hist.push_back(pack(g_win));
                if (g_hist.size() > 3) void'(g_hist.pop_front());
                g_run++;
            end else begin
                g_run = 0;
            end
            if (l_en_i) begin
                l_hist.push_back(pack(l_win));
                if (l_hist.size() > 3) void'(l_hist.pop_front());
                l_run++;
            end else begin
                l_run = 0;
            end
        end
        #1;
        compare_all(tag);
    endtask

    task automatic set_win(input bit lap, input logic [7:0] centre, input logic [7:0] other);
        for (int i = 0; i < 9; i++) begin
            if (lap) l_win[i] = (i == 4) ? centre : other;
            else     g_win[i] = (i == 4) ? centre : other;
        end
    endtask

    task automatic rand_win(input bit lap);
        for (int i = 0; i < 9; i++) begin
            if (lap) l_win[i] = 8'($urandom_range(0, 255));
            else     g_win[i] = 8'($urandom_range(0, 255));
        end
    endtask

    initial begin
        rst_i  = 1'b0;
        g_en_i = 1'b0;
        l_en_i = 1'b0;
        set_win(1'b0, 8'd0, 8'd0);
        set_win(1'b1, 8'd0, 8'd0);
        model_clear();

        #2;
        compare_all("reset");

        // Enables asserted during reset must be ignored
        g_en_i = 1'b1;
        l_en_i = 1'b1;
        set_win(1'b0, 8'd200, 8'd200);
        set_win(1'b1, 8'd200, 8'd0);
        step("en_in_reset");
        step("en_in_reset");
        g_en_i = 1'b0;
        l_en_i = 1'b0;
        rst_i  = 1'b1;
        step("idle");

        // Flat window of 100
        set_win(1'b0, 8'd100, 8'd100);
        set_win(1'b1, 8'd100, 8'd100);
        g_en_i = 1'b1;
        l_en_i = 1'b1;
        for (int i = 0; i < 5; i++) step("flat");
        check("flat_g_value", 32'(g_data_o), 32'd100);
        check("flat_l_value", 32'(l_data_o), 32'd0);

        // Impulse and inverse impulse
        set_win(1'b0, 8'd255, 8'd0);
        set_win(1'b1, 8'd255, 8'd0);
        for (int i = 0; i < 5; i++) step("impulse");
        check("impulse_g_value", 32'(g_data_o), 32'd63);
        check("impulse_l_value", 32'(l_data_o), 32'h0FF);
        set_win(1'b0, 8'd0, 8'd255);
        set_win(1'b1, 8'd0, 8'd255);
        for (int i = 0; i < 5; i++) step("inv_impulse");
        check("inv_g_value", 32'(g_data_o), 32'd191);
        check("inv_l_value", 32'(l_data_o), 32'h100);

        // Enable 2 cycles, drop 1, re-enable
        g_en_i = 1'b0;
        l_en_i = 1'b0;
        step("drop");
        step("drop");
        g_en_i = 1'b1;
        l_en_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rand_win(1'b0);
            rand_win(1'b1);
            step("gap_pre");
        end
        g_en_i = 1'b0;
        l_en_i = 1'b0;
        step("gap_low");
        g_en_i = 1'b1;
        l_en_i = 1'b1;
        for (int i = 0; i < 4; i++) step("gap_post");

        // Laplacian window arrives one cycle after the enable
        g_en_i = 1'b0;
        l_en_i = 1'b0;
        set_win(1'b1, 8'd0, 8'd0);
        step("stale_idle");
        l_en_i = 1'b1;
        step("stale_first");
        set_win(1'b1, 8'd40, 8'd0);
        for (int i = 0; i < 4; i++) step("stale_track");
        check("stale_l_value", 32'(l_data_o), 32'd160);
        check("stale_l_done", 32'(l_done_o), 32'd1);

        // Random traffic, independent per channel
        for (int n = 0; n < 300; n++) begin
            g_en_i = ($urandom_range(0, 9) < 8);
            l_en_i = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 1) == 1) rand_win(1'b0);
            if ($urandom_range(0, 1) == 1) rand_win(1'b1);
            step("rand");
        end

        // Asynchronous reset in the middle of a busy pipeline
        g_en_i = 1'b1;
        l_en_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_win(1'b0);
            rand_win(1'b1);
            step("pre_rst");
        end
        #2;
        rst_i = 1'b0;
        #1;
        model_clear();
        compare_all("async_rst");
        step("in_rst");
        rst_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_win(1'b0);
            rand_win(1'b1);
            step("post_rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gauss_laplacian_filter.md
# gauss_laplacian_filter

Dual-channel 3x3 convolution block for the image-sharpening path. It holds two independent channels:
- a Gaussian smoothing channel with an 8-bit unsigned result;
- a Laplacian edge channel with a 9-bit signed, saturated result.

The frame-level controller presents a 3x3 pixel window to a channel, holds that channel's enable high, waits for done, and stores the result into the next-stage frame buffer.

## Interface
- PIX_W, 8, pixel width; only 8 is supported.
- LAP_W, 9, Laplacian output width, two's complement.
- LATENCY, 3, number of consecutive enabled cycles before done asserts; fixed.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- g_en_i  in  1  Gaussian channel enable.
- g_data_i_0 .. g_data_i_8  in  8 each  window pixels, row-major (0 = top-left, 4 = centre, 8 = bottom-right); unsigned.
- g_data_o  out  8  Gaussian result.
- g_done_o  out  1  Gaussian result valid.
- l_en_i  in  1  Laplacian channel enable.
- l_data_i_0 .. l_data_i_8  in  8 each  window pixels, same ordering; unsigned.
- l_data_o  out  9  Laplacian result, signed.
- l_done_o  out  1  Laplacian result valid.

## Operation
- Gaussian kernel is [1 2 1; 2 4 2; 1 2 1].
  - Sum is formed in 12 bits (maximum 4080).
  - Result = sum >> 4, floor division.
  - The result always fits in 8 bits, so no clamping is needed.
- Laplacian kernel is [0 -1 0; -1 4 -1; 0 -1 0].
  - Corners 0, 2, 6 and 8 are ignored.
  - Sum is formed signed in 11 bits (range -1020..+1020).
  - Sum is saturated to 9-bit signed: >255 gives 255; <-256 gives -256 (9'h100).
- The channels are fully independent.
  - Separate enables, separate pipelines and separate done flags.
  - Activity on one channel never affects the other.
- Each channel has a 3-stage pipeline:
  - S1 registers the window.
  - S2 registers the weighted sum.
  - S3 registers the scaled (Gaussian) or saturated (Laplacian) output.
- Pipeline advance is gated by the channel enable:
  - Enable high: all stages advance every cycle.
  - Enable low: all stages hold.
- Each channel has a 2-bit enable-run counter.
  - Counts consecutive enabled cycles and saturates at LATENCY.
  - Clears on any cycle with the enable low.
  - done = (counter == LATENCY), registered.
- Inputs may change while the enable is high. The output continuously tracks the window as it moves through the pipeline.
  - The controller asserts enable one cycle before the new window arrives, so the first captured sample may be stale.
  - The controller holds enable for more than LATENCY+1 cycles, so done is read against the settled window.
- When the enable falls:
  - done deasserts on the next edge;
  - data_o holds its last value.

## Timing
- A window sampled at edge n appears on data_o after edge n+2, provided enable is high at n, n+1 and n+2.
- done rises after the 3rd consecutive rising edge with enable high. It stays high while enable stays high.
- Enable low for one cycle restarts the count: done needs 3 more enabled edges.
- Reset values, applied immediately and independent of clk_i:
  - g_data_o = 0, l_data_o = 0, g_done_o = 0, l_done_o = 0;
  - all pipeline registers = 0;
  - run counters = 0.
- Reset during operation aborts the pipeline. The first done after release needs 3 enabled edges.
- Enable high while in reset has no effect.
- Both channels enabled in the same cycle operate concurrently with no interaction.

## Structure
- Shared package `gl_filter_pkg` holds:
  - PIX_W, LAP_W and LATENCY;
  - the kernel coefficient constants;
  - the LAP_MIN (-256) and LAP_MAX (255) saturation bounds.
- Natural sub-module: `conv3x3_chan`, containing the enable-gated pipeline, run counter and done logic.
  - Parameterised by KERNEL (GAUSS / LAPLACE).
  - Instantiated twice at top level.
- The top level contains only the two instantiations and port mapping.

## Test plan
- Flat window of all 100 on both channels, enable held 5 cycles:
  - g_data_o = 100;
  - l_data_o = 0;
  - both done flags rise after the 3rd enabled edge.
- Impulse window (centre 255, others 0):
  - g_data_o = 63 (1020 >> 4);
  - l_data_o = 255 (1020 saturated).
- Inverse impulse window (centre 0, others 255):
  - g_data_o = 191 (3060 >> 4);
  - l_data_o = -256 (9'h100, saturated from -1020).
- Enable high 2 cycles, low 1 cycle, high again:
  - done stays 0 until 3 further enabled edges;
  - data_o holds during the low cycle.
- Window changes one cycle after enable rises (centre 0 to 40 on a flat-0 Laplacian window):
  - at done, l_data_o = 160;
  - the stale first sample never appears with done high.
- Assert rst_i low mid-pipeline with both channels enabled:
  - outputs and done go to 0 asynchronously, before the next clock edge;
  - after release, done requires 3 enabled edges.
